prog_check_monitor: RTL
=======================

Name: prog_check_monitor

Overview:
Synthesizable program-completion checker that sits beside the `singlecycle` core in the simulation and FPGA-debug harness. It sequences NUM_PROGS back-to-back programs. For each one it:
- watches `currentpc` until it reaches that program's end address,
- waits a settle delay,
- compares `dmemout` against an expected pass code,
- tallies the result.

A global watchdog aborts a runaway program. Pass/fail state is exposed as registered outputs for the bench, LEDs or a debug bus.

Parameters:
DATA_W, 64, width of PC, dmemout and expected-value fields
NUM_PROGS, 4, number of programs checked in sequence (1..16)
IDX_W, 4, width of program index and pass counter (must satisfy 2^IDX_W >= NUM_PROGS+1)
WDOG_W, 16, watchdog counter width
WDOG_LIMIT, 16'h00FF, watchdog terminal count (cycles)
SETTLE_CYCLES, 1, cycles waited after end PC before sampling dmemout (0 allowed)

Ports:
CLK  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  single-cycle pulse; begins the sequence at program 0
currentpc  in  DATA_W  PC from core
dmemout  in  DATA_W  data-memory read port from core
end_pc  in  NUM_PROGS*DATA_W  packed end addresses; program i occupies bits [i*DATA_W +: DATA_W]
expected  in  NUM_PROGS*DATA_W  packed expected pass codes, same packing
prog_idx  out  IDX_W  index of program being run or checked
check_valid  out  1  one-cycle pulse when a comparison completes
check_pass  out  1  result of that comparison; meaningful only with check_valid
result_map  out  NUM_PROGS  bit i set when program i passed
pass_count  out  IDX_W  number of passing programs so far
done  out  1  level; sequence completed without timeout
all_passed  out  1  level; done && pass_count==NUM_PROGS
wdog_expired  out  1  level; watchdog hit WDOG_LIMIT

Behaviour:
Reset values:
- All outputs are 0.
- State = IDLE; watchdog = 0; settle counter = 0.

States and transitions:
- IDLE: on start -> RUN. Clear prog_idx, result_map, pass_count and watchdog.
- RUN: each cycle, if currentpc >= end_pc[prog_idx] (unsigned compare):
  - go to SETTLE, loading the settle counter with SETTLE_CYCLES-1;
  - if SETTLE_CYCLES==0, go directly to CHECK.
- SETTLE: decrement the settle counter; when it is 0, go to CHECK.
- CHECK: stays exactly one cycle.
  - Compare dmemout == expected[prog_idx] and register the result.
  - check_valid pulses with check_pass in the following cycle.
  - On pass: result_map[prog_idx] <= 1 and pass_count++.
  - If prog_idx==NUM_PROGS-1 -> DONE; otherwise prog_idx++ -> RUN.
- DONE: done=1; all_passed = (pass_count==NUM_PROGS).
- TIMEOUT: wdog_expired=1.
- DONE and TIMEOUT are both terminal; start re-enters RUN and clears all status.

Watchdog:
- Increments every cycle in RUN and SETTLE. It is cumulative across programs.
- At count == WDOG_LIMIT -> TIMEOUT. This takes priority over a simultaneous end-PC match.
- It saturates and does not wrap.

Start handling and reset:
- start is ignored in RUN, SETTLE and CHECK.
- Asserting reset mid-sequence returns everything to reset values within the same cycle (asynchronous).

Latency:
- end-PC match to check_valid = SETTLE_CYCLES + 2 cycles.

Boundary cases:
- A PC that is already >= end_pc on entering RUN matches in the first RUN cycle.
- NUM_PROGS=1: CHECK goes straight to DONE.

Optional Feature:
Macro PROG_CHECK_PERPROG_WDOG_EN.
- Defined: the watchdog clears on every CHECK, so WDOG_LIMIT bounds each program individually.
- Undefined: the watchdog is cumulative from start.

Decomposition:
Shared package prog_check_pkg holds:
- the state enum (IDLE, RUN, SETTLE, CHECK, DONE, TIMEOUT),
- default width constants,
- a helper function that extracts field i from a packed vector.

Sub-module prog_check_wdog is a saturating counter with inputs clr/en, a LIMIT parameter and an expired output.

Test Plan:
1. NUM_PROGS=2, end_pc={0x68,0x34}, expected={0x123456789ABCDEF0,0xF}; drive PC 0..0x34 step 4 with dmemout=0xF at the end, then 0x38..0x68 with the correct code -> two check_valid pulses with pass=1; result_map=2'b11, pass_count=2, done=1, all_passed=1.
2. Same setup but program 1 dmemout=0xDEAD -> second pulse has pass=0; result_map=2'b01, pass_count=1, all_passed=0.
3. PC held at 0x10 forever, WDOG_LIMIT=0xFF -> wdog_expired=1 exactly 255 cycles after RUN entry; done=0; no check_valid.
4. SETTLE_CYCLES=0 and SETTLE_CYCLES=3, PC reaches end at cycle N -> check_valid at N+2 and N+5 respectively.
5. Assert reset during SETTLE of program 1 -> all outputs 0 immediately; a following start restarts at prog_idx=0.
6. With PROG_CHECK_PERPROG_WDOG_EN defined, two programs each taking 200 cycles with limit 0xFF -> no timeout, done=1. With the macro undefined, the same stimulus gives wdog_expired=1.

Source files
------------

// File: rtl/prog_check_pkg.sv
// Shared types and helpers for the program-completion checker: FSM state encoding,
// default widths and a packed-field extractor for the per-program end_pc/expected tables.
package prog_check_pkg;

  localparam int DEF_DATA_W    = 64;
  localparam int DEF_NUM_PROGS = 4;
  localparam int DEF_IDX_W     = 4;
  localparam int DEF_WDOG_W    = 16;
  localparam int MAX_PROGS     = 16;
  localparam int FIELD_VEC_W   = MAX_PROGS * DEF_DATA_W;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    SETTLE,
    CHECK,
    DONE,
    TIMEOUT
  } state_t;

  // Returns field idx of a table whose fields are width bits wide (width <= DEF_DATA_W).
  function automatic logic [DEF_DATA_W-1:0] get_field(
    input logic [FIELD_VEC_W-1:0] vec,
    input int unsigned            width,
    input int unsigned            idx
  );
    logic [DEF_DATA_W-1:0] mask;
    mask = (width >= DEF_DATA_W) ? '1
         : ((DEF_DATA_W'(1) << width) - DEF_DATA_W'(1));
    return DEF_DATA_W'(vec >> (idx * width)) & mask;
  endfunction

endpackage

// File: rtl/prog_check_wdog.sv
// Saturating watchdog: counts while en, clears on clr, holds at LIMIT.
// No backpressure; expired flags the cycle in which the count reaches LIMIT.
module prog_check_wdog #(
  parameter int           W     = 16,
  parameter logic [W-1:0] LIMIT = 16'h00FF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && count != LIMIT) begin
      count <= count + W'(1);
    end
  end

  // Raised one cycle early so the owner changes state on the same edge the count lands on LIMIT.
  assign expired = (count == LIMIT) || (en && !clr && count == LIMIT - W'(1));

endmodule

// File: rtl/prog_check_monitor.sv
// Sequences NUM_PROGS programs: wait for end PC, settle, compare dmemout; check_valid lands SETTLE_CYCLES+2 cycles after the end-PC match.
// No backpressure (pure observer); define PROG_CHECK_PERPROG_WDOG_EN to restart the watchdog for every program.
module prog_check_monitor
  import prog_check_pkg::*;
#(
  parameter int                DATA_W        = DEF_DATA_W,
  parameter int                NUM_PROGS     = DEF_NUM_PROGS,
  parameter int                IDX_W         = DEF_IDX_W,
  parameter int                WDOG_W        = DEF_WDOG_W,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT    = 16'h00FF,
  parameter int                SETTLE_CYCLES = 1
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic                        start,
  input  logic [DATA_W-1:0]           currentpc,
  input  logic [DATA_W-1:0]           dmemout,
  input  logic [NUM_PROGS*DATA_W-1:0] end_pc,
  input  logic [NUM_PROGS*DATA_W-1:0] expected,
  output logic [IDX_W-1:0]            prog_idx,
  output logic                        check_valid,
  output logic                        check_pass,
  output logic [NUM_PROGS-1:0]        result_map,
  output logic [IDX_W-1:0]            pass_count,
  output logic                        done,
  output logic                        all_passed,
  output logic                        wdog_expired
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD =
    (SETTLE_CYCLES > 1) ? SETTLE_W'(SETTLE_CYCLES - 1) : '0;

  state_t                  state;
  logic [SETTLE_W-1:0]     settle_cnt;
  logic [FIELD_VEC_W-1:0]  end_pc_ext;
  logic [FIELD_VEC_W-1:0]  expected_ext;
  logic [DATA_W-1:0]       cur_end_pc;
  logic [DATA_W-1:0]       cur_expected;
  logic                    pc_reached;
  logic                    code_match;
  logic                    last_prog;
  logic                    restart;
  logic                    wdog_clr;
  logic                    wdog_en;
  logic                    wdog_hit;
  logic [IDX_W-1:0]        pass_count_inc;

  assign end_pc_ext     = FIELD_VEC_W'(end_pc);
  assign expected_ext   = FIELD_VEC_W'(expected);
  assign cur_end_pc     = DATA_W'(get_field(end_pc_ext, DATA_W, 32'(prog_idx)));
  assign cur_expected   = DATA_W'(get_field(expected_ext, DATA_W, 32'(prog_idx)));
  assign pc_reached     = (currentpc >= cur_end_pc);
  assign code_match     = (dmemout == cur_expected);
  assign last_prog      = (prog_idx == IDX_W'(NUM_PROGS - 1));
  assign pass_count_inc = pass_count + IDX_W'(code_match);
  assign restart        = start && (state inside {IDLE, DONE, TIMEOUT});
  assign wdog_en        = (state inside {RUN, SETTLE});

`ifdef PROG_CHECK_PERPROG_WDOG_EN
  assign wdog_clr = restart || (state == CHECK);
`else
  assign wdog_clr = restart;
`endif

  prog_check_wdog #(
    .W     (WDOG_W),
    .LIMIT (WDOG_LIMIT)
  ) u_wdog (
    .clk     (CLK),
    .rst     (reset),
    .clr     (wdog_clr),
    .en      (wdog_en),
    .expired (wdog_hit)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      settle_cnt   <= '0;
      prog_idx     <= '0;
      check_valid  <= 1'b0;
      check_pass   <= 1'b0;
      result_map   <= '0;
      pass_count   <= '0;
      done         <= 1'b0;
      all_passed   <= 1'b0;
      wdog_expired <= 1'b0;
    end else begin
      check_valid <= 1'b0;
      case (state)
        IDLE, DONE, TIMEOUT: begin
          if (start) begin
            state        <= RUN;
            prog_idx     <= '0;
            result_map   <= '0;
            pass_count   <= '0;
            check_pass   <= 1'b0;
            done         <= 1'b0;
            all_passed   <= 1'b0;
            wdog_expired <= 1'b0;
          end
        end
        RUN: begin
          // Watchdog wins over an end-PC match in the same cycle.
          if (wdog_hit) begin
            state        <= TIMEOUT;
            wdog_expired <= 1'b1;
          end else if (pc_reached) begin
            if (SETTLE_CYCLES == 0) begin
              state <= CHECK;
            end else begin
              state      <= SETTLE;
              settle_cnt <= SETTLE_LOAD;
            end
          end
        end
        SETTLE: begin
          if (wdog_hit) begin
            state        <= TIMEOUT;
            wdog_expired <= 1'b1;
          end else if (settle_cnt == '0) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt - SETTLE_W'(1);
          end
        end
        CHECK: begin
          check_valid <= 1'b1;
          check_pass  <= code_match;
          if (code_match) begin
            result_map <= result_map | (NUM_PROGS'(1) << prog_idx);
            pass_count <= pass_count_inc;
          end
          if (last_prog) begin
            state      <= DONE;
            done       <= 1'b1;
            all_passed <= (pass_count_inc == IDX_W'(NUM_PROGS));
          end else begin
            prog_idx <= prog_idx + IDX_W'(1);
            state    <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
